// File: rtl/cmp_unit_arbiter.sv
// cmp_unit_arbiter
//   Round-robin arbiter sharing one compare datapath among NREQ requesters.
//   At most one grant per cycle. Each requester owns a one-deep registered
//   response slot that holds until its consumer takes it.
//
// Ports
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   en           : arbitration enable (0 = no new grants, responses still drain)
//   req_valid    : per-requester request valid
//   req_ready    : one-hot (or zero) accept for the current cycle
//   req_in1/2    : operands, slice i belongs to requester i
//   req_ctrl     : 4-bit compare code, slice i belongs to requester i
//   rsp_valid    : response slot i holds a result
//   rsp_pred     : predicate result of slot i
//   rsp_illegal  : slot i was produced by an undefined control code (9..15)
//   rsp_ready    : consumer i takes its response
//   grant_id     : index of the current-cycle grant (0 when none)
//   gnt_cnt      : saturating count of all grants
module cmp_unit_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDW   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_in1,
    input  logic [NREQ*WIDTH-1:0]   req_in2,
    input  logic [NREQ*4-1:0]       req_ctrl,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [NREQ-1:0]         rsp_pred,
    output logic [NREQ-1:0]         rsp_illegal,
    input  logic [NREQ-1:0]         rsp_ready,
    output logic [IDW-1:0]          grant_id,
    output logic [15:0]             gnt_cnt
);

    logic [NREQ-1:0]  rsp_valid_q;
    logic [NREQ-1:0]  rsp_pred_q;
    logic [NREQ-1:0]  rsp_illegal_q;
    logic [IDW-1:0]   ptr_q;
    logic [15:0]      gnt_cnt_q;

    logic [NREQ-1:0]  elig;
    logic [NREQ-1:0]  gnt_onehot;
    logic             gnt_found;
    logic [IDW-1:0]   gnt_idx;
    int unsigned      cand;

    logic [WIDTH-1:0] sel_in1;
    logic [WIDTH-1:0] sel_in2;
    logic [3:0]       sel_ctrl;
    logic             cmp_pred;
    logic             cmp_illegal;

    // A slot can accept a new result if it is empty or being drained this cycle.
    assign elig = req_valid & (~rsp_valid_q | rsp_ready);

    // Search ptr, ptr+1, ... modulo NREQ. Gated by rst_n so nothing is
    // accepted while reset is asserted.
    always_comb begin
        gnt_found  = 1'b0;
        gnt_idx    = '0;
        gnt_onehot = '0;
        cand       = 0;
        if (en && rst_n) begin
            for (int unsigned j = 0; j < NREQ; j++) begin
                cand = 32'(ptr_q) + j;
                if (cand >= NREQ) begin
                    cand = cand - NREQ;
                end
                if (!gnt_found && elig[cand[IDW-1:0]]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = cand[IDW-1:0];
                end
            end
        end
        if (gnt_found) begin
            gnt_onehot[gnt_idx] = 1'b1;
        end
    end

    // Operand mux driven by the one-hot grant.
    always_comb begin
        sel_in1  = '0;
        sel_in2  = '0;
        sel_ctrl = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_onehot[i]) begin
                sel_in1  = req_in1[i*WIDTH +: WIDTH];
                sel_in2  = req_in2[i*WIDTH +: WIDTH];
                sel_ctrl = req_ctrl[i*4 +: 4];
            end
        end
    end

    always_comb begin
        cmp_pred    = 1'b0;
        cmp_illegal = 1'b0;
        case (sel_ctrl)
            4'd0:    cmp_pred = (sel_in1 == '0);
            4'd1:    cmp_pred = (sel_in1 != '0);
            4'd2:    cmp_pred = 1'b1;
            4'd3:    cmp_pred = ($signed(sel_in1) >= $signed(sel_in2));
            4'd4:    cmp_pred = ($signed(sel_in1) <  $signed(sel_in2));
            4'd5:    cmp_pred = (sel_in1 >= sel_in2);
            4'd6:    cmp_pred = (sel_in1 <  sel_in2);
            4'd7:    cmp_pred = (sel_in1 == sel_in2);
            4'd8:    cmp_pred = (sel_in1 != sel_in2);
            default: cmp_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q   <= '0;
            rsp_pred_q    <= '0;
            rsp_illegal_q <= '0;
            ptr_q         <= '0;
            gnt_cnt_q     <= '0;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                // A regrant takes priority over a consume: the slot stays full.
                if (gnt_onehot[i]) begin
                    rsp_valid_q[i]   <= 1'b1;
                    rsp_pred_q[i]    <= cmp_pred;
                    rsp_illegal_q[i] <= cmp_illegal;
                end else if (rsp_ready[i]) begin
                    rsp_valid_q[i]   <= 1'b0;
                    rsp_pred_q[i]    <= 1'b0;
                    rsp_illegal_q[i] <= 1'b0;
                end
            end
            if (gnt_found) begin
                ptr_q <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
                if (gnt_cnt_q != 16'hFFFF) begin
                    gnt_cnt_q <= gnt_cnt_q + 16'd1;
                end
            end
        end
    end

    assign req_ready   = gnt_onehot;
    assign grant_id    = gnt_idx;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_pred    = rsp_pred_q;
    assign rsp_illegal = rsp_illegal_q;
    assign gnt_cnt     = gnt_cnt_q;

endmodule

// File: tb/tb_cmp_unit_arbiter.sv
module tb_cmp_unit_arbiter;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_in1;
    logic [127:0] req_in2;
    logic [15:0]  req_ctrl;
    logic [3:0]   rsp_valid;
    logic [3:0]   rsp_pred;
    logic [3:0]   rsp_illegal;
    logic [3:0]   rsp_ready;
    logic [1:0]   grant_id;
    logic [15:0]  gnt_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0] id;
        logic       pred;
        logic       ill;
    } exp_t;

    exp_t sb[$];

    cmp_unit_arbiter #(
        .WIDTH(32),
        .NREQ (4),
        .IDW  (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_in1    (req_in1),
        .req_in2    (req_in2),
        .req_ctrl   (req_ctrl),
        .rsp_valid  (rsp_valid),
        .rsp_pred   (rsp_pred),
        .rsp_illegal(rsp_illegal),
        .rsp_ready  (rsp_ready),
        .grant_id   (grant_id),
        .gnt_cnt    (gnt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] c);
        req_in1[i*32 +: 32] = a;
        req_in2[i*32 +: 32] = b;
        req_ctrl[i*4 +: 4]  = c;
    endtask

    // One clock cycle: check the grant at the negedge, push the expected
    // response for the hand-predicted grantee, return at posedge+1.
    task automatic cyc(input string name, input logic [3:0] exp_rdy, input logic [1:0] exp_id,
                       input logic ep, input logic ei);
        exp_t e;
        @(negedge clk);
        check($sformatf("%s.req_ready", name), 32'(req_ready), 32'(exp_rdy));
        check($sformatf("%s.grant_id", name), 32'(grant_id), 32'(exp_id));
        if (exp_rdy != 4'b0000) begin
            e.id   = exp_id;
            e.pred = ep;
            e.ill  = ei;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        en        = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
    endtask

    // Monitor: a response is taken when rsp_valid & rsp_ready; compare it
    // against the oldest expectation queued for that slot.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (rsp_valid[i] && rsp_ready[i]) begin
                    int pos;
                    pos = -1;
                    for (int e = 0; e < sb.size(); e++) begin
                        if (pos < 0 && sb[e].id == 2'(i)) pos = e;
                    end
                    checks++;
                    if (pos < 0) begin
                        failures++;
                        $display("FAIL rsp_unexpected slot=%0d actual=valid required=none", i);
                    end else begin
                        if (rsp_pred[i] !== sb[pos].pred || rsp_illegal[i] !== sb[pos].ill) begin
                            failures++;
                            $display("FAIL rsp slot=%0d actual pred=%0b ill=%0b required pred=%0b ill=%0b",
                                     i, rsp_pred[i], rsp_illegal[i], sb[pos].pred, sb[pos].ill);
                        end
                        sb.delete(pos);
                    end
                end
            end
        end
    end

    logic [3:0] t4_ctrl [4] = '{4'd4, 4'd6, 4'd3, 4'd5};
    logic       t4_pred [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0] t5_ctrl [5] = '{4'd12, 4'd2, 4'd0, 4'd9, 4'd15};
    logic       t5_pred [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       t5_ill  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       t6_pred [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        req_in1 = '0;
        req_in2 = '0;
        req_ctrl = '0;
        rst_n = 1'b0;
        en = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = '0;

        // 1. Reset: nothing accepted while held, state cleared.
        #12;
        check("rst.req_ready", 32'(req_ready), 32'h0);
        check("rst.rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst.gnt_cnt", 32'(gnt_cnt), 32'h0);
        check("rst.grant_id", 32'(grant_id), 32'h0);
        do_reset();
        en = 1'b1;
        cyc("idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        check("idle.gnt_cnt", 32'(gnt_cnt), 32'h0);

        // 2. Single requester, held response, regrant only once consumed.
        set_req(0, 32'd5, 32'd5, 4'd7);
        req_valid = 4'b0001;
        cyc("t2.first", 4'b0001, 2'd0, 1'b1, 1'b0);
        set_req(0, 32'd3, 32'd7, 4'd7);
        for (int k = 0; k < 3; k++) begin
            check("t2.hold_valid", 32'(rsp_valid[0]), 32'h1);
            check("t2.hold_pred", 32'(rsp_pred[0]), 32'h1);
            cyc("t2.blocked", 4'b0000, 2'd0, 1'b0, 1'b0);
        end
        rsp_ready = 4'b0001;
        cyc("t2.regrant", 4'b0001, 2'd0, 1'b0, 1'b0);
        check("t2.replace_valid", 32'(rsp_valid[0]), 32'h1);
        check("t2.replace_pred", 32'(rsp_pred[0]), 32'h0);
        req_valid = 4'b0000;
        cyc("t2.drain", 4'b0000, 2'd0, 1'b0, 1'b0);
        check("t2.empty", 32'(rsp_valid), 32'h0);
        check("t2.gnt_cnt", 32'(gnt_cnt), 32'd2);

        // 3. Round robin from ptr=0.
        do_reset();
        en = 1'b1;
        set_req(0, 32'd0, 32'd0, 4'd0);
        set_req(1, 32'd0, 32'd0, 4'd1);
        set_req(2, 32'd1, 32'd2, 4'd8);
        set_req(3, 32'd0, 32'd0, 4'd12);
        req_valid = 4'b1111;
        rsp_ready = 4'b1111;
        cyc("t3.g0", 4'b0001, 2'd0, 1'b1, 1'b0);
        cyc("t3.g1", 4'b0010, 2'd1, 1'b0, 1'b0);
        cyc("t3.g2", 4'b0100, 2'd2, 1'b1, 1'b0);
        cyc("t3.g3", 4'b1000, 2'd3, 1'b0, 1'b1);
        cyc("t3.g4", 4'b0001, 2'd0, 1'b1, 1'b0);
        check("t3.gnt_cnt", 32'(gnt_cnt), 32'd5);

        // 4. Signed vs unsigned, requester 2 alone.
        req_valid = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            set_req(2, 32'hFFFF_FFFF, 32'd1, t4_ctrl[k]);
            cyc("t4.cmp", 4'b0100, 2'd2, t4_pred[k], 1'b0);
        end

        // 5. Illegal and trivial codes, requester 3 alone.
        req_valid = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            set_req(3, 32'd0, 32'd7, t5_ctrl[k]);
            cyc("t5.code", 4'b1000, 2'd3, t5_pred[k], t5_ill[k]);
        end
        req_valid = 4'b0000;
        cyc("t5.drain", 4'b0000, 2'd0, 1'b0, 1'b0);
        check("t5.empty", 32'(rsp_valid), 32'h0);

        // en=0 blocks grants; ptr unchanged (last grant was 3 -> ptr 0).
        en = 1'b0;
        set_req(0, 32'd0, 32'd0, 4'd2);
        req_valid = 4'b0001;
        cyc("en0.blocked", 4'b0000, 2'd0, 1'b0, 1'b0);
        en = 1'b1;
        req_valid = 4'b0011;
        set_req(1, 32'd0, 32'd0, 4'd2);
        cyc("en1.grant", 4'b0001, 2'd0, 1'b1, 1'b0);
        req_valid = 4'b0000;
        cyc("en1.drain", 4'b0000, 2'd0, 1'b0, 1'b0);

        // 6. Back-to-back on slot 1, then async reset mid-stream.
        req_valid = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            set_req(1, 32'(k), 32'd2, 4'd7);
            cyc("t6.b2b", 4'b0010, 2'd1, t6_pred[k], 1'b0);
            check("t6.valid", 32'(rsp_valid[1]), 32'h1);
            check("t6.pred", 32'(rsp_pred[1]), 32'(t6_pred[k]));
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("t6.async_valid", 32'(rsp_valid), 32'h0);
        check("t6.async_ready", 32'(req_ready), 32'h0);
        check("t6.async_cnt", 32'(gnt_cnt), 32'h0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 32'd0, 32'd0, 4'd2);
        req_valid = 4'b1111;
        cyc("t6.ptr0", 4'b0001, 2'd0, 1'b1, 1'b0);
        req_valid = 4'b0000;
        cyc("t6.drain", 4'b0000, 2'd0, 1'b0, 1'b0);
        check("end.empty", 32'(rsp_valid), 32'h0);
        check("end.gnt_cnt", 32'(gnt_cnt), 32'd1);
        check("end.sb_left", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
